// File: rtl/asym_outbuf_gen2_if.sv
// Pop-side bus of the asymmetric output buffer: FIFO word interface plus subword delivery.
interface asym_outbuf_gen2_if #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
);
   localparam int K  = IN_WIDTH / OUT_WIDTH;
   localparam int CW = $clog2(K) + 1;

   logic                 init_pop_n;
   logic                 pop_req_n;
   logic [IN_WIDTH-1:0]  data_in;
   logic [CW-1:0]        in_cnt;
   logic                 fifo_empty;
   logic                 pop_wd_n;
   logic [OUT_WIDTH-1:0] data_out;
   logic                 data_valid;
   logic                 part_wd;
   logic                 pop_error;

   modport master (
      output init_pop_n, pop_req_n, data_in, in_cnt, fifo_empty,
      input  pop_wd_n, data_out, data_valid, part_wd, pop_error
   );

   modport slave (
      input  init_pop_n, pop_req_n, data_in, in_cnt, fifo_empty,
      output pop_wd_n, data_out, data_valid, part_wd, pop_error
   );
endinterface

// File: rtl/asym_outbuf_gen2.sv
// Wide-to-narrow output buffer: prefetches one FIFO word and delivers it one subword per
// requesting cycle, honouring a per-word valid-subword count and refilling without a bubble.
module asym_outbuf_gen2 #(
   parameter int IN_WIDTH   = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int ERR_MODE   = 0,
   parameter int BYTE_ORDER = 0
) (
   input logic                clk_pop,
   input logic                rst_pop,
   asym_outbuf_gen2_if.slave  bus
);
   localparam int K  = IN_WIDTH / OUT_WIDTH;
   localparam int CW = $clog2(K) + 1;

   logic [IN_WIDTH-1:0]  buf_data;
   logic [CW-1:0]        buf_cnt;
   logic [CW-1:0]        idx;
   logic                 buf_valid;
   logic                 err;

   logic                 accept;
   logic                 last;
   logic                 load;
   logic                 underflow;
   logic [CW-1:0]        cnt_eff;
   logic [OUT_WIDTH-1:0] sel;

   always_comb begin
      accept    = buf_valid & ~bus.pop_req_n;
      last      = accept & (idx == buf_cnt - CW'(1));
      load      = ~bus.fifo_empty & (~buf_valid | last) & ~rst_pop & bus.init_pop_n;
      underflow = ~buf_valid & ~bus.pop_req_n;
      cnt_eff   = (bus.in_cnt == '0) ? CW'(K) : bus.in_cnt;
   end

   // Constant-index mux keeps every part-select static; empty buffer yields zero.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (buf_valid && (idx == CW'(i))) begin
            if (BYTE_ORDER == 0)
               sel = buf_data[IN_WIDTH-1-i*OUT_WIDTH -: OUT_WIDTH];
            else
               sel = buf_data[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   always_ff @(posedge clk_pop or posedge rst_pop) begin
      if (rst_pop) begin
         buf_data  <= '0;
         buf_cnt   <= '0;
         idx       <= '0;
         buf_valid <= 1'b0;
         err       <= 1'b0;
      end else if (!bus.init_pop_n) begin
         buf_data  <= '0;
         buf_cnt   <= '0;
         idx       <= '0;
         buf_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (load) begin
            buf_data  <= bus.data_in;
            buf_cnt   <= cnt_eff;
            idx       <= '0;
            buf_valid <= 1'b1;
         end else if (last) begin
            buf_valid <= 1'b0;
            idx       <= '0;
         end else if (accept) begin
            idx <= idx + CW'(1);
         end

         if (ERR_MODE == 0) begin
            if (underflow)
               err <= 1'b1;
         end else begin
            err <= underflow;
         end
      end
   end

   assign bus.pop_wd_n   = ~load;
   assign bus.data_out   = sel;
   assign bus.data_valid = buf_valid;
   assign bus.part_wd    = buf_valid & (idx != '0);
   assign bus.pop_error  = err;
endmodule

// File: tb/tb_asym_outbuf_gen2.sv
// Directed bench: u0 (sticky error, MSB-first) and u1 (pulse error, LSB-first) fed by queue FIFO models.
module tb_asym_outbuf_gen2;
   logic clk_pop = 1'b0;
   logic rst_pop = 1'b1;
   always #5 clk_pop = ~clk_pop;

   asym_outbuf_gen2_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) b0 ();
   asym_outbuf_gen2_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) b1 ();

   asym_outbuf_gen2 #(.IN_WIDTH(32), .OUT_WIDTH(8), .ERR_MODE(0), .BYTE_ORDER(0)) u0 (
      .clk_pop(clk_pop), .rst_pop(rst_pop), .bus(b0));
   asym_outbuf_gen2 #(.IN_WIDTH(32), .OUT_WIDTH(8), .ERR_MODE(1), .BYTE_ORDER(1)) u1 (
      .clk_pop(clk_pop), .rst_pop(rst_pop), .bus(b1));

   int unsigned passed = 0;
   int unsigned fails  = 0;
   int unsigned total  = 0;

   logic [31:0] fw0[$];
   logic [2:0]  fc0[$];
   logic [31:0] fw1[$];
   logic [2:0]  fc1[$];
   logic [7:0]  exp0[$];
   logic [7:0]  exp1[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add_exp(input int u, input logic [31:0] w, input logic [2:0] c);
      int n;
      logic [31:0] s;
      n = (c == 3'd0) ? 4 : int'(c);
      for (int i = 0; i < n; i++) begin
         if (u == 0) begin
            s = w >> (8 * (3 - i));
            exp0.push_back(s[7:0]);
         end else begin
            s = w >> (8 * i);
            exp1.push_back(s[7:0]);
         end
      end
   endtask

   task automatic refresh();
      b0.fifo_empty = (fw0.size() == 0);
      b0.data_in    = (fw0.size() != 0) ? fw0[0] : 32'h0;
      b0.in_cnt     = (fc0.size() != 0) ? fc0[0] : 3'd0;
      b1.fifo_empty = (fw1.size() == 0);
      b1.data_in    = (fw1.size() != 0) ? fw1[0] : 32'h0;
      b1.in_cnt     = (fc1.size() != 0) ? fc1[0] : 3'd0;
   endtask

   task automatic push(input int u, input logic [31:0] w, input logic [2:0] c);
      if (u == 0) begin
         fw0.push_back(w);
         fc0.push_back(c);
      end else begin
         fw1.push_back(w);
         fc1.push_back(c);
      end
      add_exp(u, w, c);
      refresh();
   endtask

   // After reset the word in the buffer is lost; only words still in the FIFO are owed.
   task automatic rebuild0();
      exp0.delete();
      foreach (fw0[i]) add_exp(0, fw0[i], fc0[i]);
   endtask

   task automatic sb_check();
      logic [7:0] e;
      if (b0.data_valid && !b0.pop_req_n) begin
         e = (exp0.size() != 0) ? exp0.pop_front() : 8'hxx;
         chk("sb0_data", 32'(b0.data_out), 32'(e));
      end
      if (b1.data_valid && !b1.pop_req_n) begin
         e = (exp1.size() != 0) ? exp1.pop_front() : 8'hxx;
         chk("sb1_data", 32'(b1.data_out), 32'(e));
      end
   endtask

   // Inputs are set at the falling edge; FIFO pops follow the pre-edge pop_wd_n.
   task automatic tick();
      logic p0, p1;
      logic [31:0] dw;
      logic [2:0]  dc;
      sb_check();
      p0 = b0.pop_wd_n;
      p1 = b1.pop_wd_n;
      @(posedge clk_pop);
      #1;
      if (!p0 && fw0.size() != 0) begin dw = fw0.pop_front(); dc = fc0.pop_front(); end
      if (!p1 && fw1.size() != 0) begin dw = fw1.pop_front(); dc = fc1.pop_front(); end
      refresh();
      @(negedge clk_pop);
   endtask

   logic exp_pw [0:8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      b0.init_pop_n = 1'b1;
      b1.init_pop_n = 1'b1;
      b0.pop_req_n  = 1'b1;
      b1.pop_req_n  = 1'b1;
      refresh();
      @(negedge clk_pop);

      // Reset holds everything idle even with a non-empty FIFO
      push(0, 32'hAABBCCDD, 3'd4);
      push(0, 32'h11223344, 3'd0);
      #1;
      chk("rst_pw0",   32'(b0.pop_wd_n),   32'd1);
      chk("rst_dv0",   32'(b0.data_valid), 32'd0);
      chk("rst_dout0", 32'(b0.data_out),   32'd0);
      chk("rst_part0", 32'(b0.part_wd),    32'd0);
      chk("rst_err0",  32'(b0.pop_error),  32'd0);
      chk("rst_dv1",   32'(b1.data_valid), 32'd0);
      chk("rst_pw1",   32'(b1.pop_wd_n),   32'd1);
      tick();

      // Streaming across a word boundary, second word with cnt 0 meaning full
      rst_pop = 1'b0;
      #1;
      chk("lat_dv0", 32'(b0.data_valid), 32'd0);
      chk("stream_pw0", 32'(b0.pop_wd_n), 32'(exp_pw[0]));
      tick();
      b0.pop_req_n = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk("stream_dv0",   32'(b0.data_valid), 32'd1);
         chk("stream_pw0",   32'(b0.pop_wd_n),   32'(exp_pw[i]));
         chk("stream_part0", 32'(b0.part_wd),    32'(((i - 1) % 4) != 0));
         tick();
      end
      b0.pop_req_n = 1'b1;
      #1;
      chk("drain_dv0",   32'(b0.data_valid), 32'd0);
      chk("drain_dout0", 32'(b0.data_out),   32'd0);
      chk("drain_err0",  32'(b0.pop_error),  32'd0);

      // Partial word: only two subwords delivered
      push(0, 32'h12345678, 3'd2);
      #1;
      chk("part_pw0", 32'(b0.pop_wd_n), 32'd0);
      tick();
      b0.pop_req_n = 1'b0;
      #1;
      chk("part_dout0", 32'(b0.data_out), 32'h12);
      tick();
      #1;
      chk("part_last_pw0", 32'(b0.pop_wd_n), 32'd1);
      chk("part_last_part0", 32'(b0.part_wd), 32'd1);
      tick();
      b0.pop_req_n = 1'b1;
      #1;
      chk("part_end_dv0",   32'(b0.data_valid), 32'd0);
      chk("part_end_dout0", 32'(b0.data_out),   32'd0);
      chk("part_sb_empty0", 32'(exp0.size()),   32'd0);

      // Stall mid-word, then reset mid-word
      push(0, 32'hA1B2C3D4, 3'd4);
      push(0, 32'h55667788, 3'd4);
      #1;
      tick();
      b0.pop_req_n = 1'b0;
      tick();
      tick();
      b0.pop_req_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_dout0", 32'(b0.data_out), 32'hC3);
         chk("stall_part0", 32'(b0.part_wd),  32'd1);
         chk("stall_pw0",   32'(b0.pop_wd_n), 32'd1);
         tick();
      end
      rst_pop = 1'b1;
      #1;
      chk("midrst_dv0",   32'(b0.data_valid), 32'd0);
      chk("midrst_dout0", 32'(b0.data_out),   32'd0);
      chk("midrst_part0", 32'(b0.part_wd),    32'd0);
      chk("midrst_pw0",   32'(b0.pop_wd_n),   32'd1);
      rebuild0();
      tick();
      rst_pop = 1'b0;
      #1;
      chk("postrst_pw0", 32'(b0.pop_wd_n), 32'd0);
      tick();
      b0.pop_req_n = 1'b0;
      #1;
      chk("postrst_first0", 32'(b0.data_out), 32'h55);
      for (int i = 0; i < 4; i++) tick();
      b0.pop_req_n = 1'b1;
      #1;
      chk("postrst_sb_empty0", 32'(exp0.size()), 32'd0);

      // Sticky underflow, cleared only by init
      b0.pop_req_n = 1'b0;
      #1;
      chk("uf_pre_err0", 32'(b0.pop_error), 32'd0);
      tick();
      b0.pop_req_n = 1'b1;
      #1;
      chk("uf_err0", 32'(b0.pop_error), 32'd1);
      tick();
      #1;
      chk("uf_hold_err0", 32'(b0.pop_error), 32'd1);
      push(0, 32'hCAFEF00D, 3'd4);
      b0.init_pop_n = 1'b0;
      #1;
      chk("init_pw0", 32'(b0.pop_wd_n), 32'd1);
      tick();
      b0.init_pop_n = 1'b1;
      #1;
      chk("init_err0", 32'(b0.pop_error),  32'd0);
      chk("init_dv0",  32'(b0.data_valid), 32'd0);
      chk("init_pw_after0", 32'(b0.pop_wd_n), 32'd0);
      tick();
      b0.pop_req_n = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      b0.pop_req_n = 1'b1;
      #1;
      chk("init_sb_empty0", 32'(exp0.size()), 32'd0);

      // LSB-first ordering and pulsed underflow on u1
      push(1, 32'hAABBCCDD, 3'd4);
      #1;
      tick();
      b1.pop_req_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("bo1_part1", 32'(b1.part_wd), 32'(i != 0));
         tick();
      end
      #1;
      chk("uf1_pre_err", 32'(b1.pop_error),  32'd0);
      chk("uf1_dv",      32'(b1.data_valid), 32'd0);
      tick();
      #1;
      chk("uf1_pulse_a", 32'(b1.pop_error), 32'd1);
      tick();
      b1.pop_req_n = 1'b1;
      #1;
      chk("uf1_pulse_b", 32'(b1.pop_error), 32'd1);
      tick();
      #1;
      chk("uf1_clear", 32'(b1.pop_error), 32'd0);
      chk("bo1_sb_empty", 32'(exp1.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
